uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial-to-parallel UART receiver, 8N1 framing, LSB first. It is the receive-side counterpart of the team's UART transmitter. It synchronises the asynchronous RX pin, validates the start bit at mid-bit, and samples 8 data bits plus the stop bit at bit centres. Each completed byte is presented on a valid/ready holding register, and framing and overrun errors are flagged.

Parameters:
CLKS_PER_BIT, 217, i_clk cycles per bit (25 MHz / 115200); legal range >= 4
DATA_BITS, 8, data bits per frame; legal range 5..8

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous, active-high reset
i_rx  input  1  asynchronous serial line, idle high
i_ready  input  1  consumer accepts o_data when high with o_valid
o_data  output  DATA_BITS  received byte, LSB = first data bit on the wire
o_valid  output  1  o_data holds an unconsumed byte
o_busy  output  1  high whenever the FSM is not in IDLE
o_frame_err  output  1  one-cycle pulse: stop bit sampled low
o_overrun  output  1  one-cycle pulse: byte completed while o_valid high and i_ready low; new byte dropped

Behaviour:
- Reset (i_clk, i_reset, synchronous, active-high):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Bit counter and baud counter clear; shift register clears.
  - Both synchroniser flops are set to 1 (idle line level).
  - Reset asserted mid-frame aborts the frame. No valid, error, or overrun pulse is produced for it.
- Synchroniser: i_rx passes through a 2-FF chain; only the second stage (rx_s) is used. The fixed 2-cycle input latency is included in all timing below.
- Baud counter: counts 0..CLKS_PER_BIT-1. HALF = (CLKS_PER_BIT-1)/2 (integer division).
- FSM states and transitions:
  - IDLE: when rx_s = 0, clear the baud counter and go to START.
  - START: at baud count = HALF, re-sample rx_s.
    - If 0: clear the counter and go to DATA.
    - If 1: the low was a glitch; return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the MSB of the shift register and shift right, i.e. shift <= {rx_s, shift[DATA_BITS-1:1]}. After DATA_BITS samples, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1: deliver the byte and return to IDLE.
    - If 0: pulse o_frame_err for 1 cycle, discard the byte, and go to BREAK.
  - BREAK: wait until rx_s = 1, then go to IDLE. This prevents a held-low line from retriggering START.
- Delivery (same cycle as the stop sample, registered):
  - If o_valid = 0, or o_valid & i_ready in that cycle: load o_data and set o_valid = 1.
  - Otherwise: keep the old o_data and o_valid, and pulse o_overrun for 1 cycle.
- Handshake:
  - o_valid clears on the cycle after o_valid & i_ready, unless a new byte is delivered in that same cycle, in which case o_valid stays 1 with the new data.
  - o_data is stable while o_valid = 1.
- Latency: o_valid rises 2 + HALF + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles (±1 for start-edge alignment) after the falling edge of the start bit on i_rx.
- Back-to-back frames: after the stop sample the FSM returns to IDLE at mid-stop-bit. The next start edge is therefore detected with no dead time.
- o_frame_err and o_overrun never assert in the same cycle. A framed-bad byte never touches o_data or o_valid.

Test Plan:
(All scenarios use CLKS_PER_BIT=16 and drive the line with a bit-period-accurate serial model; i_ready=1 unless stated.)
1. Send 0xA5, 8N1 -> o_valid rises once with o_data=0xA5 within the latency formula ±1; o_frame_err=0 and o_overrun=0 throughout; o_busy high from start detect to the stop sample.
2. Send 0x00 then 0xFF back-to-back with no idle gap -> two o_valid events carrying 0x00 then 0xFF; no errors.
3. Start glitch: hold i_rx low for 4 cycles, then high -> FSM returns to IDLE; no o_valid and no o_frame_err. A following 0x3C is received correctly.
4. Frame 0x55 with stop bit forced 0, then line held low for 3 bit times, then released -> exactly one o_frame_err pulse; o_valid stays 0; a following 0x81 is received correctly.
5. Overrun: i_ready=0, send 0x11 then 0x22 -> o_valid=1 with o_data=0x11 after the first frame; one o_overrun pulse at the second stop sample; o_data stays 0x11. Raising i_ready for 1 cycle clears o_valid.
6. Reset mid-frame: assert i_reset during data bit 3 of 0xC3 -> all outputs 0 the next cycle; no pulses; a subsequent 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver, LSB first. Two-flop input synchroniser,
//             mid-bit start validation, bit-centre sampling, valid/ready
//             holding register with framing-error and overrun pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CNT_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_BITS-1:0]   shift;

    logic                   cnt_clr;
    logic                   shift_en;
    logic                   stop_ok;
    logic                   stop_bad;
    logic                   baud_done;
    logic                   baud_half;

    assign baud_done = (baud_cnt == CNT_LAST);
    assign baud_half = (baud_cnt == CNT_HALF);
    assign o_busy    = (state != IDLE);

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_clr    = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                // A start bit still low at its centre is genuine.
                if (baud_half) begin
                    if (!rx_s) begin
                        cnt_clr    = 1'b1;
                        next_state = DATA;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (baud_done) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets the next start edge be seen at once.
                if (baud_done) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        stop_ok    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        next_state = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a held-low line cannot retrigger.
                if (rx_s) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Baud counter, bit counter and shift register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            if (cnt_clr) begin
                baud_cnt <= '0;
            end else if (state == START || state == DATA || state == STOP) begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (shift_en) begin
                shift <= {rx_s, shift[DATA_BITS-1:1]};
            end
        end
    end

    // Holding register with handshake, plus the one-cycle error pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= stop_bad;
            o_overrun   <= 1'b0;
            if (stop_ok) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shift;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Self-checking bench for uart_rx with a bit-accurate serial
//             driver and an expected-byte scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int DB   = 8;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 2 + HALF + (DB + 1) * CPB + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          ready;
    logic [DB-1:0] data;
    logic          valid;
    logic          busy;
    logic          ferr;
    logic          ovr;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx        (rx),
        .i_ready     (ready),
        .o_data      (data),
        .o_valid     (valid),
        .o_busy      (busy),
        .o_frame_err (ferr),
        .o_overrun   (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples just after the falling edge, when inputs for the
    // next rising edge are settled, and records transfers and pulses.
    logic [DB-1:0] got_data [64];
    int            got_n    = 0;
    int            rise_n   = 0;
    int            rise_cyc = 0;
    int            ferr_n   = 0;
    int            ovr_n    = 0;
    int            both_n   = 0;
    logic          valid_d  = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (valid && ready) begin
                got_data[got_n % 64] = data;
                got_n = got_n + 1;
            end
            if (valid && !valid_d) begin
                rise_n   = rise_n + 1;
                rise_cyc = cyc;
            end
            if (ferr) ferr_n = ferr_n + 1;
            if (ovr) ovr_n = ovr_n + 1;
            if (ferr && ovr) both_n = both_n + 1;
        end
        valid_d = valid;
    end

    int            checks   = 0;
    int            failures = 0;
    logic [DB-1:0] exp_q [$];
    int            rd       = 0;

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop_bit, input logic expect_out);
        if (expect_out) exp_q.push_back(b);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Pop every expected byte and compare with what the monitor captured.
    task automatic drain_scoreboard(input string name);
        logic [DB-1:0] e;
        int            waited;
        while (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            waited = 0;
            while (got_n <= rd && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            checks++;
            if (got_n <= rd) begin
                failures++;
                $display("FAIL %s timeout: no byte received, expected 0x%02h", name, e);
                exp_q.delete();
            end else begin
                if (got_data[rd % 64] !== e) begin
                    failures++;
                    $display("FAIL %s data: got 0x%02h expected 0x%02h", name, got_data[rd % 64], e);
                end
                rd++;
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (got_n !== rd) begin
            failures++;
            $display("FAIL %s extra bytes: received %0d expected %0d", name, got_n, rd);
            rd = got_n;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({data, valid, busy, ferr, ovr} !== '0) begin
            failures++;
            $display("FAIL reset_state: got %b expected all zero", {data, valid, busy, ferr, ovr});
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_single_byte();
        int r0, f0, o0, t_fall, lat;
        r0 = rise_n; f0 = ferr_n; o0 = ovr_n;
        t_fall = cyc;
        exp_q.push_back(8'hA5);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hA5 >> i));
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid_frame: got %b expected 1", busy);
        end
        for (int i = 4; i < DB; i++) drive_bit(1'(8'hA5 >> i));
        drive_bit(1'b1);
        idle(4);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_frame: got %b expected 0", busy);
        end
        checks++;
        if (rise_n - r0 !== 1) begin
            failures++;
            $display("FAIL single_valid_events: got %0d expected 1", rise_n - r0);
        end
        lat = rise_cyc - t_fall;
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            failures++;
            $display("FAIL latency: got %0d expected %0d +/-1", lat, LAT);
        end
        checks++;
        if (ferr_n !== f0 || ovr_n !== o0) begin
            failures++;
            $display("FAIL single_errors: frame_err %0d overrun %0d expected 0 0", ferr_n - f0, ovr_n - o0);
        end
        drain_scoreboard("single_a5");
    endtask

    task automatic test_back_to_back();
        int f0, o0;
        f0 = ferr_n; o0 = ovr_n;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(8);
        checks++;
        if (ferr_n !== f0 || ovr_n !== o0) begin
            failures++;
            $display("FAIL b2b_errors: frame_err %0d overrun %0d expected 0 0", ferr_n - f0, ovr_n - o0);
        end
        drain_scoreboard("back_to_back");
    endtask

    task automatic test_start_glitch();
        int r0, f0;
        r0 = rise_n; f0 = ferr_n;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CPB);
        checks++;
        if (rise_n !== r0 || ferr_n !== f0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_ignored: valid %0d frame_err %0d busy %b expected 0 0 0", rise_n - r0, ferr_n - f0, busy);
        end
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(4);
        drain_scoreboard("after_glitch");
    endtask

    task automatic test_frame_error();
        int r0, f0;
        r0 = rise_n; f0 = ferr_n;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        idle(2 * CPB);
        checks++;
        if (ferr_n - f0 !== 1) begin
            failures++;
            $display("FAIL frame_err_pulses: got %0d expected 1", ferr_n - f0);
        end
        checks++;
        if (rise_n !== r0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL frame_err_no_valid: valid events %0d valid %b expected 0 0", rise_n - r0, valid);
        end
        send_frame(8'h81, 1'b1, 1'b1);
        idle(4);
        drain_scoreboard("after_frame_err");
    endtask

    task automatic test_overrun();
        int o0, f0;
        o0 = ovr_n; f0 = ferr_n;
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        idle(2);
        checks++;
        if (valid !== 1'b1 || data !== 8'h11) begin
            failures++;
            $display("FAIL overrun_first_held: valid %b data 0x%02h expected 1 0x11", valid, data);
        end
        send_frame(8'h22, 1'b1, 1'b0);
        idle(2);
        checks++;
        if (ovr_n - o0 !== 1 || ferr_n !== f0) begin
            failures++;
            $display("FAIL overrun_pulse: overrun %0d frame_err %0d expected 1 0", ovr_n - o0, ferr_n - f0);
        end
        checks++;
        if (valid !== 1'b1 || data !== 8'h11) begin
            failures++;
            $display("FAIL overrun_data_kept: valid %b data 0x%02h expected 1 0x11", valid, data);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL overrun_ready_clears: valid %b expected 0", valid);
        end
        ready = 1'b1;
        drain_scoreboard("overrun");
    endtask

    task automatic test_reset_mid_frame();
        int r0, f0, o0;
        logic [DB-1:0] b;
        b  = 8'hC3;
        r0 = rise_n; f0 = ferr_n; o0 = ovr_n;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx = b[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({data, valid, busy, ferr, ovr} !== '0) begin
            failures++;
            $display("FAIL reset_mid_frame_outputs: got %b expected all zero", {data, valid, busy, ferr, ovr});
        end
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(CPB * 6);
        checks++;
        if (rise_n !== r0 || ferr_n !== f0 || ovr_n !== o0) begin
            failures++;
            $display("FAIL reset_mid_frame_pulses: valid %0d frame_err %0d overrun %0d expected 0 0 0",
                     rise_n - r0, ferr_n - f0, ovr_n - o0);
        end
        send_frame(8'h7E, 1'b1, 1'b1);
        idle(4);
        drain_scoreboard("after_reset");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_start_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        checks++;
        if (both_n !== 0) begin
            failures++;
            $display("FAIL err_and_overrun_together: got %0d cycles expected 0", both_n);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
